// File: rtl/trmm_kernel.sv
// trmm_kernel: in-place TRMM core, B := alpha * (B + strict_lower(A)^T * B),
// sequenced over three single-port sequential memories (A, B, alpha).
module trmm_kernel #(
  parameter int M     = 8,
  parameter int N     = 12,
  parameter int WIDTH = 32,
  parameter int IDX   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  output logic             done,
  output logic [IDX-1:0]   A_int_addr0,
  output logic [IDX-1:0]   A_int_addr1,
  output logic             A_int_read_en,
  input  logic [WIDTH-1:0] A_int_read_data,
  input  logic             A_int_read_done,
  output logic             A_int_write_en,
  output logic [WIDTH-1:0] A_int_write_data,
  input  logic             A_int_write_done,
  output logic [IDX-1:0]   B_int_addr0,
  output logic [IDX-1:0]   B_int_addr1,
  output logic             B_int_read_en,
  input  logic [WIDTH-1:0] B_int_read_data,
  input  logic             B_int_read_done,
  output logic             B_int_write_en,
  output logic [WIDTH-1:0] B_int_write_data,
  input  logic             B_int_write_done,
  output logic             alpha_int_addr0,
  output logic             alpha_int_read_en,
  input  logic [WIDTH-1:0] alpha_int_read_data,
  input  logic             alpha_int_read_done,
  output logic             alpha_int_write_en,
  output logic [WIDTH-1:0] alpha_int_write_data,
  input  logic             alpha_int_write_done
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LD_ALPHA = 4'd1,
    S_RD_BIJ   = 4'd2,
    S_RD_A     = 4'd3,
    S_RD_BK    = 4'd4,
    S_MAC      = 4'd5,
    S_SCALE    = 4'd6,
    S_WR_B     = 4'd7,
    S_NEXT     = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  localparam logic [IDX-1:0] I_LAST   = IDX'(M - 1);
  localparam logic [IDX-1:0] J_LAST   = IDX'(N - 1);
  localparam logic [IDX-1:0] IDX_ZERO = {IDX{1'b0}};
  localparam logic [IDX-1:0] IDX_ONE  = {{(IDX-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic               pend_r, pend_s;     // one access issued, waiting for its done
  logic [IDX-1:0]     i_r, i_s, j_r, j_s, k_r, k_s;
  logic [WIDTH-1:0]   acc_r, acc_s, alpha_r, alpha_s, a_r, a_s, b_r, b_s;
  logic               done_r, done_s;
  logic [IDX-1:0]     a_addr0_r, a_addr0_s, a_addr1_r, a_addr1_s;
  logic [IDX-1:0]     b_addr0_r, b_addr0_s, b_addr1_r, b_addr1_s;
  logic               a_ren_r, a_ren_s, b_ren_r, b_ren_s, b_wen_r, b_wen_s;
  logic               al_ren_r, al_ren_s;
  logic [WIDTH-1:0]   b_wdata_r, b_wdata_s;
  logic               unused_s;

  // Next-state and next-output logic; request strobes default low so each lasts one cycle.
  always_comb begin
    state_s   = state_r;
    pend_s    = pend_r;
    i_s       = i_r;
    j_s       = j_r;
    k_s       = k_r;
    acc_s     = acc_r;
    alpha_s   = alpha_r;
    a_s       = a_r;
    b_s       = b_r;
    done_s    = 1'b0;
    a_ren_s   = 1'b0;
    b_ren_s   = 1'b0;
    b_wen_s   = 1'b0;
    al_ren_s  = 1'b0;
    a_addr0_s = a_addr0_r;
    a_addr1_s = a_addr1_r;
    b_addr0_s = b_addr0_r;
    b_addr1_s = b_addr1_r;
    b_wdata_s = b_wdata_r;
    case (state_r)
      S_IDLE: begin
        pend_s = 1'b0;
        i_s    = IDX_ZERO;
        j_s    = IDX_ZERO;
        if (go) begin
          state_s = S_LD_ALPHA;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LD_ALPHA: begin
        if (!pend_r) begin
          al_ren_s = 1'b1;
          pend_s   = 1'b1;
        end else if (alpha_int_read_done) begin
          alpha_s = alpha_int_read_data;
          pend_s  = 1'b0;
          state_s = S_RD_BIJ;
        end else begin
          pend_s = 1'b1;
        end
      end
      S_RD_BIJ: begin
        if (!pend_r) begin
          b_ren_s   = 1'b1;
          b_addr0_s = i_r;
          b_addr1_s = j_r;
          pend_s    = 1'b1;
        end else if (B_int_read_done) begin
          acc_s  = B_int_read_data;
          pend_s = 1'b0;
          k_s    = i_r + IDX_ONE;
          // The last row has no k > i terms, so it goes straight to scaling.
          if (i_r == I_LAST) begin
            state_s = S_SCALE;
          end else begin
            state_s = S_RD_A;
          end
        end else begin
          pend_s = 1'b1;
        end
      end
      S_RD_A: begin
        if (!pend_r) begin
          a_ren_s   = 1'b1;
          a_addr0_s = k_r;
          a_addr1_s = i_r;
          pend_s    = 1'b1;
        end else if (A_int_read_done) begin
          a_s     = A_int_read_data;
          pend_s  = 1'b0;
          state_s = S_RD_BK;
        end else begin
          pend_s = 1'b1;
        end
      end
      S_RD_BK: begin
        if (!pend_r) begin
          b_ren_s   = 1'b1;
          b_addr0_s = k_r;
          b_addr1_s = j_r;
          pend_s    = 1'b1;
        end else if (B_int_read_done) begin
          b_s     = B_int_read_data;
          pend_s  = 1'b0;
          state_s = S_MAC;
        end else begin
          pend_s = 1'b1;
        end
      end
      S_MAC: begin
        acc_s = acc_r + a_r * b_r;
        if (k_r == I_LAST) begin
          state_s = S_SCALE;
        end else begin
          k_s     = k_r + IDX_ONE;
          state_s = S_RD_A;
        end
      end
      S_SCALE: begin
        acc_s   = alpha_r * acc_r;
        state_s = S_WR_B;
      end
      S_WR_B: begin
        if (!pend_r) begin
          b_wen_s   = 1'b1;
          b_addr0_s = i_r;
          b_addr1_s = j_r;
          b_wdata_s = acc_r;
          pend_s    = 1'b1;
        end else if (B_int_write_done) begin
          pend_s  = 1'b0;
          state_s = S_NEXT;
        end else begin
          pend_s = 1'b1;
        end
      end
      S_NEXT: begin
        if (j_r == J_LAST) begin
          j_s = IDX_ZERO;
          if (i_r == I_LAST) begin
            done_s  = 1'b1;
            state_s = S_DONE;
          end else begin
            i_s     = i_r + IDX_ONE;
            state_s = S_RD_BIJ;
          end
        end else begin
          j_s     = j_r + IDX_ONE;
          state_s = S_RD_BIJ;
        end
      end
      S_DONE: begin
        state_s = S_IDLE;
      end
      default: begin
        pend_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered memory-interface outputs; reset aborts any run at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      pend_r    <= 1'b0;
      i_r       <= IDX_ZERO;
      j_r       <= IDX_ZERO;
      k_r       <= IDX_ZERO;
      acc_r     <= {WIDTH{1'b0}};
      alpha_r   <= {WIDTH{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      done_r    <= 1'b0;
      a_ren_r   <= 1'b0;
      b_ren_r   <= 1'b0;
      b_wen_r   <= 1'b0;
      al_ren_r  <= 1'b0;
      a_addr0_r <= IDX_ZERO;
      a_addr1_r <= IDX_ZERO;
      b_addr0_r <= IDX_ZERO;
      b_addr1_r <= IDX_ZERO;
      b_wdata_r <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      pend_r    <= pend_s;
      i_r       <= i_s;
      j_r       <= j_s;
      k_r       <= k_s;
      acc_r     <= acc_s;
      alpha_r   <= alpha_s;
      a_r       <= a_s;
      b_r       <= b_s;
      done_r    <= done_s;
      a_ren_r   <= a_ren_s;
      b_ren_r   <= b_ren_s;
      b_wen_r   <= b_wen_s;
      al_ren_r  <= al_ren_s;
      a_addr0_r <= a_addr0_s;
      a_addr1_r <= a_addr1_s;
      b_addr0_r <= b_addr0_s;
      b_addr1_r <= b_addr1_s;
      b_wdata_r <= b_wdata_s;
    end
  end

  assign done                 = done_r;
  assign A_int_addr0          = a_addr0_r;
  assign A_int_addr1          = a_addr1_r;
  assign A_int_read_en        = a_ren_r;
  assign A_int_write_en       = 1'b0;
  assign A_int_write_data     = {WIDTH{1'b0}};
  assign B_int_addr0          = b_addr0_r;
  assign B_int_addr1          = b_addr1_r;
  assign B_int_read_en        = b_ren_r;
  assign B_int_write_en       = b_wen_r;
  assign B_int_write_data     = b_wdata_r;
  assign alpha_int_addr0      = 1'b0;
  assign alpha_int_read_en    = al_ren_r;
  assign alpha_int_write_en   = 1'b0;
  assign alpha_int_write_data = {WIDTH{1'b0}};

  // A and alpha are read-only, so their write completions carry no information.
  assign unused_s = A_int_write_done ^ alpha_int_write_done;

endmodule

// File: tb/tb_trmm_kernel.sv
// tb_trmm_kernel: memory models, spec-level TRMM reference, write scoreboard and monitor.
module tb_trmm_kernel;
  localparam int M          = 8;
  localparam int N          = 12;
  localparam int RUN_BUDGET = 8000;

  typedef struct packed {
    logic [3:0]  r;
    logic [3:0]  c;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset, go, done;
  logic [3:0]  A_int_addr0, A_int_addr1, B_int_addr0, B_int_addr1;
  logic        A_int_read_en, A_int_read_done, A_int_write_en;
  logic [31:0] A_int_read_data, A_int_write_data;
  logic        B_int_read_en, B_int_read_done, B_int_write_en, B_int_write_done;
  logic [31:0] B_int_read_data, B_int_write_data;
  logic        alpha_int_addr0, alpha_int_read_en, alpha_int_read_done, alpha_int_write_en;
  logic [31:0] alpha_int_read_data, alpha_int_write_data;
  logic        A_int_write_done = 1'b0;
  logic        alpha_int_write_done = 1'b0;

  logic [31:0] mem_a [M][M];
  logic [31:0] mem_b [M][N];
  logic [31:0] mem_alpha;
  logic [31:0] a_ld [M][M];
  logic [31:0] b_ld [M][N];
  logic [31:0] alpha_ld;
  logic        ld_req;

  logic [31:0] exp_mem [M][N];
  wr_t         exp_q[$];
  int          run_q[$];
  int          checks = 0;
  int          failures = 0;
  int          run_cyc = 0;

  always #5 clk = ~clk;

  trmm_kernel dut (
    .clk(clk), .reset(reset), .go(go), .done(done),
    .A_int_addr0(A_int_addr0), .A_int_addr1(A_int_addr1),
    .A_int_read_en(A_int_read_en), .A_int_read_data(A_int_read_data),
    .A_int_read_done(A_int_read_done), .A_int_write_en(A_int_write_en),
    .A_int_write_data(A_int_write_data), .A_int_write_done(A_int_write_done),
    .B_int_addr0(B_int_addr0), .B_int_addr1(B_int_addr1),
    .B_int_read_en(B_int_read_en), .B_int_read_data(B_int_read_data),
    .B_int_read_done(B_int_read_done), .B_int_write_en(B_int_write_en),
    .B_int_write_data(B_int_write_data), .B_int_write_done(B_int_write_done),
    .alpha_int_addr0(alpha_int_addr0), .alpha_int_read_en(alpha_int_read_en),
    .alpha_int_read_data(alpha_int_read_data), .alpha_int_read_done(alpha_int_read_done),
    .alpha_int_write_en(alpha_int_write_en), .alpha_int_write_data(alpha_int_write_data),
    .alpha_int_write_done(alpha_int_write_done)
  );

  // Sequential memories with one-cycle read latency; A and alpha ignore writes.
  always @(posedge clk) begin
    if (ld_req) begin
      mem_a     <= a_ld;
      mem_b     <= b_ld;
      mem_alpha <= alpha_ld;
    end else if (B_int_write_en) begin
      mem_b[B_int_addr0[2:0]][B_int_addr1] <= B_int_write_data;
    end
    A_int_read_done     <= A_int_read_en;
    A_int_read_data     <= mem_a[A_int_addr0[2:0]][A_int_addr1[2:0]];
    B_int_read_done     <= B_int_read_en;
    B_int_read_data     <= (B_int_addr1 < 4'd12) ? mem_b[B_int_addr0[2:0]][B_int_addr1] : 32'd0;
    B_int_write_done    <= B_int_write_en;
    alpha_int_read_done <= alpha_int_read_en;
    alpha_int_read_data <= mem_alpha;
  end

  // Monitor: reset state, read-only memories, triangle reads, scoreboard pops, done and watchdog.
  always begin
    @(negedge clk or negedge reset);
    #1;
    if (!reset) begin
      checks++;
      if (done !== 1'b0 || B_int_write_en !== 1'b0 || B_int_read_en !== 1'b0 ||
          A_int_read_en !== 1'b0 || alpha_int_read_en !== 1'b0 ||
          A_int_addr0 !== 4'd0 || A_int_addr1 !== 4'd0 || B_int_addr0 !== 4'd0 ||
          B_int_addr1 !== 4'd0 || B_int_write_data !== 32'd0) begin
        failures++;
        $display("FAIL reset_state: done=%0b bwen=%0b bren=%0b aren=%0b alren=%0b addrs=%0h/%0h/%0h/%0h wdata=%0h, required all 0",
                 done, B_int_write_en, B_int_read_en, A_int_read_en, alpha_int_read_en,
                 A_int_addr0, A_int_addr1, B_int_addr0, B_int_addr1, B_int_write_data);
      end
      exp_q.delete();
      run_q.delete();
      run_cyc = 0;
    end else begin
      checks++;
      if (A_int_write_en !== 1'b0 || alpha_int_write_en !== 1'b0) begin
        failures++;
        $display("FAIL ro_write: A_we=%0b alpha_we=%0b, required 0", A_int_write_en, alpha_int_write_en);
      end
      if (A_int_read_en) begin
        checks++;
        if (!(A_int_addr0 > A_int_addr1 && A_int_addr0 < 4'd8)) begin
          failures++;
          $display("FAIL a_triangle: read A[%0d][%0d], required row > col", A_int_addr0, A_int_addr1);
        end
      end
      if (B_int_write_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_write: B[%0d][%0d]=%h, required no write", B_int_addr0, B_int_addr1, B_int_write_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({B_int_addr0, B_int_addr1, B_int_write_data} !== e) begin
            failures++;
            $display("FAIL b_write: got B[%0d][%0d]=%h, required B[%0d][%0d]=%h",
                     B_int_addr0, B_int_addr1, B_int_write_data, e.r, e.c, e.d);
          end
        end
      end
      if (done) begin
        checks++;
        if (run_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: done=1 with no run pending, required 0");
        end else begin
          int bad;
          void'(run_q.pop_front());
          run_cyc = 0;
          if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL done_early: %0d writes missing, required 0", exp_q.size());
            exp_q.delete();
          end
          checks++;
          bad = 0;
          for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
              if (mem_b[i][j] !== exp_mem[i][j]) begin
                if (bad == 0) begin
                  $display("FAIL final_b: B[%0d][%0d]=%h, required %h", i, j, mem_b[i][j], exp_mem[i][j]);
                end
                bad++;
              end
            end
          end
          if (bad != 0) begin
            failures++;
          end
        end
      end else if (run_q.size() != 0) begin
        run_cyc++;
        if (run_cyc > RUN_BUDGET) begin
          checks++;
          failures++;
          $display("FAIL timeout: no done after %0d cycles, %0d writes outstanding, required done", run_cyc, exp_q.size());
          exp_q.delete();
          run_q.delete();
          run_cyc = 0;
        end
      end
    end
  end

  task automatic do_load();
    @(negedge clk);
    ld_req = 1'b1;
    @(posedge clk);
    #1;
    ld_req = 1'b0;
  endtask

  // Reference: B'[i][j] = alpha*(B[i][j] + sum_{k>i} A[k][i]*B[k][j]) on the pre-run B,
  // which equals the in-place result because rows below i are still unmodified.
  task automatic start_run();
    logic [31:0] acc, res;
    wr_t e;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = mem_b[i][j];
        for (int k = i + 1; k < M; k++) begin
          acc = acc + mem_a[k][i] * mem_b[k][j];
        end
        res = mem_alpha * acc;
        exp_mem[i][j] = res;
        e.r = 4'(i);
        e.c = 4'(j);
        e.d = res;
        exp_q.push_back(e);
      end
    end
    run_q.push_back(1);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_run();
    while (run_q.size() != 0) begin
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic fill(input int mode, input logic [31:0] alpha_v);
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        case (mode)
          0:       a_ld[i][j] = 32'd0;
          1:       a_ld[i][j] = 32'd1;
          2:       a_ld[i][j] = (i > j) ? 32'd0 : 32'hDEADBEEF;
          default: a_ld[i][j] = $urandom;
        endcase
      end
      for (int j = 0; j < N; j++) begin
        case (mode)
          0, 1:    b_ld[i][j] = 32'd1;
          2:       b_ld[i][j] = 32'd5;
          default: b_ld[i][j] = $urandom;
        endcase
      end
    end
    alpha_ld = alpha_v;
  endtask

  initial begin
    reset  = 1'b0;
    go     = 1'b0;
    ld_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    fill(0, 32'd2);        do_load(); start_run(); wait_run();   // every B = 2
    fill(1, 32'd1);        do_load(); start_run(); wait_run();   // row i = 8 - i
    fill(3, 32'd0);        do_load(); start_run(); wait_run();   // all zero
    fill(2, 32'd3);        do_load(); start_run(); wait_run();   // all 15
    fill(3, 32'd2);
    b_ld[7][0] = 32'h7FFFFFFF;
    do_load(); start_run(); wait_run();                          // B[7][0] wraps to FFFFFFFE
    fill(3, $urandom);     do_load(); start_run(); wait_run();
    fill(3, 32'($urandom_range(0, 15)) - 32'd7); do_load(); start_run(); wait_run();

    // Abort a run while a B write strobe is active, then restart from the current contents.
    fill(3, $urandom);     do_load(); start_run();
    for (int c = 0; c < 5000; c++) begin
      if (exp_q.size() <= 91 && B_int_write_en) break;
      @(negedge clk);
    end
    #2;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    start_run(); wait_run();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
